// File: rtl/lift_motion_ctrl.sv
`timescale 1ns/1ps
// lift_motion_ctrl
// Car-motion controller that sits directly behind the request queue registers.
// Collective scheduling: the car keeps its committed direction while requests
// lie ahead, then reverses. While the door is open it strobes the clear lines
// so the queue block drops the requests served at the current floor.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-high reset
//   i_up_req_queue   pending hall-up requests, one bit per floor
//   i_dn_req_queue   pending hall-down requests, one bit per floor
//   i_flr_req_queue  pending in-car floor requests, one bit per floor
//   o_flr_pos        one-hot current floor
//   o_up_clr         clear up request at o_flr_pos (door open, going up)
//   o_dn_clr         clear down request at o_flr_pos (door open, going down)
//   o_flr_clr        clear car request at o_flr_pos (door open)
//   o_dir_up         committed direction, 1 = up
//   o_moving         car travelling between floors
//   o_door_open      door open
//   o_state          debug view of the FSM state register
module lift_motion_ctrl #(
  parameter int N_FLOORS      = 12,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] i_up_req_queue,
  input  logic [N_FLOORS-1:0] i_dn_req_queue,
  input  logic [N_FLOORS-1:0] i_flr_req_queue,
  output logic [N_FLOORS-1:0] o_flr_pos,
  output logic                o_up_clr,
  output logic                o_dn_clr,
  output logic                o_flr_clr,
  output logic                o_dir_up,
  output logic                o_moving,
  output logic                o_door_open,
  output logic [1:0]          o_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MOVE_UP = 2'd1;
  localparam logic [1:0] S_MOVE_DN = 2'd2;
  localparam logic [1:0] S_DOOR    = 2'd3;

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

  logic [1:0]          state, state_n;
  logic [N_FLOORS-1:0] pos, pos_n;
  logic                dir_up, dir_n;
  logic [TW-1:0]       timer, timer_n;

  logic [N_FLOORS-1:0] all_req;
  logic                in_move;
  logic                travel_done;
  logic [N_FLOORS-1:0] step_pos;
  logic [N_FLOORS-1:0] cand_pos;
  logic [N_FLOORS-1:0] below_m, above_m;
  logic                req_above, req_below, req_here;
  logic                flr_here, up_here, dn_here;
  logic                ahead, behind, hall_fwd, hall_back;
  logic                door_dir, at_end, stop_here, go_idle;

  assign all_req     = i_up_req_queue | i_dn_req_queue | i_flr_req_queue;
  assign in_move     = (state == S_MOVE_UP) || (state == S_MOVE_DN);
  assign travel_done = in_move && (timer == TRAVEL_LAST);

  // Shift is saturated at either end so pos can never leave the shaft.
  always_comb begin
    step_pos = pos;
    if (state == S_MOVE_UP && !pos[N_FLOORS-1]) step_pos = pos << 1;
    if (state == S_MOVE_DN && !pos[0])          step_pos = pos >> 1;
  end

  // All request decoding is done against the floor the car will be at after
  // this edge, so the stop decision at a terminal count sees the new floor.
  assign cand_pos = travel_done ? step_pos : pos;

  // For a one-hot vector, pos-1 sets exactly the bits below it.
  assign below_m = cand_pos - N_FLOORS'(1);
  assign above_m = ~(below_m | cand_pos);

  assign req_above = |(all_req & above_m);
  assign req_below = |(all_req & below_m);
  assign req_here  = |(all_req & cand_pos);
  assign flr_here  = |(i_flr_req_queue & cand_pos);
  assign up_here   = |(i_up_req_queue & cand_pos);
  assign dn_here   = |(i_dn_req_queue & cand_pos);

  // dir_up already equals the travel direction while moving.
  assign ahead     = dir_up ? req_above : req_below;
  assign behind    = dir_up ? req_below : req_above;
  assign hall_fwd  = dir_up ? up_here : dn_here;
  assign hall_back = dir_up ? dn_here : up_here;

  // Direction committed on door entry: it decides which hall call is cleared.
  assign door_dir  = (ahead | hall_fwd) ? dir_up :
                     (hall_back | behind) ? ~dir_up : dir_up;

  assign at_end    = dir_up ? cand_pos[N_FLOORS-1] : cand_pos[0];
  assign stop_here = flr_here | hall_fwd | (~ahead & req_here) | at_end;
  assign go_idle   = ~ahead & ~req_here;

  always_comb begin
    state_n = state;
    pos_n   = pos;
    dir_n   = dir_up;
    timer_n = timer;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (req_here) begin
          state_n = S_DOOR;
          dir_n   = door_dir;
        end else if (req_above && (dir_up || !req_below)) begin
          state_n = S_MOVE_UP;
          dir_n   = 1'b1;
        end else if (req_below) begin
          state_n = S_MOVE_DN;
          dir_n   = 1'b0;
        end
      end
      S_MOVE_UP, S_MOVE_DN: begin
        if (travel_done) begin
          pos_n   = cand_pos;
          timer_n = '0;
          if (stop_here) begin
            state_n = S_DOOR;
            dir_n   = door_dir;
          end else if (go_idle) begin
            state_n = S_IDLE;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        if (timer == DOOR_LAST) begin
          state_n = S_IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      pos    <= N_FLOORS'(1);
      dir_up <= 1'b1;
      timer  <= '0;
    end else begin
      state  <= state_n;
      pos    <= pos_n;
      dir_up <= dir_n;
      timer  <= timer_n;
    end
  end

  assign o_flr_pos   = pos;
  assign o_dir_up    = dir_up;
  assign o_moving    = in_move;
  assign o_door_open = (state == S_DOOR);
  assign o_flr_clr   = o_door_open;
  assign o_up_clr    = o_door_open & dir_up;
  assign o_dn_clr    = o_door_open & ~dir_up;
  assign o_state     = state;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
`timescale 1ns/1ps
module tb_lift_motion_ctrl;

  localparam int NF = 12;
  localparam int TC = 4;
  localparam int DC = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NF-1:0] up_q, dn_q, flr_q;
  logic [NF-1:0] press_up = '0, press_dn = '0, press_flr = '0;
  logic [NF-1:0] o_flr_pos;
  logic          o_up_clr, o_dn_clr, o_flr_clr, o_dir_up, o_moving, o_door_open;
  logic [1:0]    o_state;

  lift_motion_ctrl #(.N_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .i_up_req_queue(up_q), .i_dn_req_queue(dn_q), .i_flr_req_queue(flr_q),
    .o_flr_pos(o_flr_pos), .o_up_clr(o_up_clr), .o_dn_clr(o_dn_clr),
    .o_flr_clr(o_flr_clr), .o_dir_up(o_dir_up), .o_moving(o_moving),
    .o_door_open(o_door_open), .o_state(o_state)
  );

  // Request queue registers upstream of the controller: presses set bits,
  // clear strobes drop the bit at the current floor (clear wins).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      up_q  <= '0;
      dn_q  <= '0;
      flr_q <= '0;
    end else begin
      up_q  <= (up_q  | press_up)  & ~(o_up_clr  ? o_flr_pos : '0);
      dn_q  <= (dn_q  | press_dn)  & ~(o_dn_clr  ? o_flr_pos : '0);
      flr_q <= (flr_q | press_flr) & ~(o_flr_clr ? o_flr_pos : '0);
    end
  end

  // ---------------- scoreboard ----------------
  // Entry = {floor one-hot, up_clr, dn_clr, flr_clr} expected at each door opening.
  logic [NF+2:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  bit prev_door = 1'b0;
  int door_len = 0;
  bit inv_bad = 1'b0;

  function automatic logic [NF+2:0] ev(input logic [NF-1:0] p, input logic u,
                                       input logic d, input logic f);
    return {p, u, d, f};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic monitor_step();
    logic [NF+2:0] e;
    if ($countones(o_flr_pos) != 1) inv_bad = 1'b1;
    if ((o_up_clr | o_dn_clr | o_flr_clr) && !o_door_open) inv_bad = 1'b1;
    if (o_moving && o_door_open) inv_bad = 1'b1;
    if (o_door_open && !prev_door) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_stop: door opened at pos 0x%0h, no stop expected", o_flr_pos);
      end else begin
        e = exp_q.pop_front();
        check("stop", {17'd0, o_flr_pos, o_up_clr, o_dn_clr, o_flr_clr}, {17'd0, e});
      end
      door_len = 1;
    end else if (o_door_open) begin
      door_len++;
    end else if (prev_door) begin
      check("door_len", door_len, DC);
    end
    prev_door = o_door_open;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor_step();
  endtask

  task automatic press(input logic [NF-1:0] u, input logic [NF-1:0] d, input logic [NF-1:0] f);
    press_up  = u;
    press_dn  = d;
    press_flr = f;
    tick();
    press_up  = '0;
    press_dn  = '0;
    press_flr = '0;
  endtask

  task automatic settle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || o_moving || o_door_open || (|(up_q | dn_q | flr_q))) && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL %s_timeout: got %0d cycles required under 600 (%0d stops left)", name, n, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic wait_pos(input logic [NF-1:0] mask, input string name);
    int n = 0;
    while (o_flr_pos !== mask && n < 200) begin
      tick();
      n++;
    end
    check(name, o_flr_pos, mask);
  endtask

  task automatic reset_check(input string name);
    #2 reset = 1'b1;
    #1;
    check({name, "_pos"}, o_flr_pos, 12'h001);
    check({name, "_dir"}, o_dir_up, 1'b1);
    check({name, "_flags"}, {o_moving, o_door_open, o_up_clr, o_dn_clr, o_flr_clr}, 5'b0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    prev_door = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NF-1:0] up;
    logic [NF-1:0] dn;
    logic [NF-1:0] flr;
    int            n_stops;
    logic [NF+2:0] stop0;
    logic [NF+2:0] stop1;
  } vec_t;
  vec_t vecs[7];

  initial begin
    // Start floor / direction of each row is where the previous row left the car.
    // floor 5 up: up8 + dn3 -> 8 first (passing 6,7), then reverse to 3
    vecs[0] = '{12'h100, 12'h008, 12'h000, 2, ev(12'h100, 1, 0, 1), ev(12'h008, 0, 1, 1)};
    // floor 3 down, nothing below: car 11 -> run to top
    vecs[1] = '{12'h000, 12'h000, 12'h800, 1, ev(12'h800, 1, 0, 1), '0};
    // at top, car 11 only: opens at once, nothing below so stays up
    vecs[2] = '{12'h000, 12'h000, 12'h800, 1, ev(12'h800, 1, 0, 1), '0};
    // at top, car 11 + dn2: opens at once, direction flips, then down to 2
    vecs[3] = '{12'h000, 12'h004, 12'h800, 2, ev(12'h800, 0, 1, 1), ev(12'h004, 0, 1, 1)};
    // floor 2 down, dn5: climbs to 5, flips to down on arrival
    vecs[4] = '{12'h000, 12'h020, 12'h000, 1, ev(12'h020, 0, 1, 1), '0};
    // floor 5 down, car 2 + car 9: down to 2 first, then up to 9
    vecs[5] = '{12'h000, 12'h000, 12'h204, 2, ev(12'h004, 1, 0, 1), ev(12'h200, 1, 0, 1)};
    // floor 9 up, car 10 + car 7: current direction wins
    vecs[6] = '{12'h000, 12'h000, 12'h480, 2, ev(12'h400, 0, 1, 1), ev(12'h080, 0, 1, 1)};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    prev_door = 1'b0;

    // reset state
    check("rst_pos", o_flr_pos, 12'h001);
    check("rst_dir", o_dir_up, 1'b1);
    check("rst_flags", {o_moving, o_door_open, o_up_clr, o_dn_clr, o_flr_clr}, 5'b0);

    // car request 5 from floor 0: exact timing
    exp_q.push_back(ev(12'h020, 1, 0, 1));
    press('0, '0, 12'h020);
    check("t1_not_yet_moving", o_moving, 1'b0);
    tick();
    check("t1_moving", o_moving, 1'b1);
    check("t1_start_pos", o_flr_pos, 12'h001);
    repeat (19) tick();
    check("t1_pos_before_arrival", o_flr_pos, 12'h010);
    tick();
    check("t1_arrival_pos", o_flr_pos, 12'h020);
    check("t1_door", {o_door_open, o_flr_clr, o_up_clr, o_moving}, 4'b1110);
    repeat (5) tick();
    check("t1_door_last_cycle", o_door_open, 1'b1);
    tick();
    check("t1_closed_idle", {o_door_open, o_moving}, 2'b00);
    settle("t1");

    // press at the current floor, and again while the door is open
    exp_q.push_back(ev(12'h020, 1, 0, 1));
    press('0, '0, 12'h020);
    tick();
    check("t5_door", o_door_open, 1'b1);
    tick();
    press('0, '0, 12'h020);
    check("t5_press_cleared", flr_q, 12'h000);
    check("t5_door_still_open", o_door_open, 1'b1);
    settle("t5");

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].n_stops >= 1) exp_q.push_back(vecs[i].stop0);
      if (vecs[i].n_stops >= 2) exp_q.push_back(vecs[i].stop1);
      press(vecs[i].up, vecs[i].dn, vecs[i].flr);
      settle($sformatf("vec%0d", i));
    end

    // reset while moving down from floor 7 (dir_up=0 beforehand)
    press('0, '0, 12'h008);
    wait_pos(12'h020, "t4a_reach5");
    tick();
    check("t4a_mid_move", {o_moving, o_dir_up}, 2'b10);
    reset_check("t4a");

    // reset mid MOVE_UP between floors 3 and 4
    press('0, '0, 12'h040);
    wait_pos(12'h008, "t4b_reach3");
    tick();
    check("t4b_mid_move", o_moving, 1'b1);
    reset_check("t4b");
    repeat (3) tick();
    check("t4b_after_idle", {o_flr_pos, o_moving, o_door_open}, {12'h001, 2'b00});

    check("invariants", inv_bad, 1'b0);
    check("stops_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
